multicycle_sequencer: RTL

- Multi-cycle phase sequencer for the RV32I core: FETCH -> DECODE -> EXEC -> MEM -> WB.
- Qualifies the combinational decoder's RUWr/DMWr with per-phase enables.
- Runs the instruction- and data-memory req/ready handshakes and counts retired instructions.
- Halts on an illegal opcode or a memory timeout.
- Sits between the instruction register/decoder and the PC, IR, ALU-out, MDR, register-file and memory write ports.

---
 rtl/rv32i_pkg.sv | 36 +++
 rtl/handshake_watchdog.sv | 31 +++
 rtl/multicycle_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I sequencer types: phase encoding, opcode map and halt error codes.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM_TO = 2'b10;
  localparam logic [1:0] ERR_DMEM_TO = 2'b11;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/handshake_watchdog.sv
// Counts consecutive stalled request cycles; expired flags the last stalled cycle allowed.
// Combinational expired, zero latency; a MEM_TIMEOUT of 0 never expires.
module handshake_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit EN = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // expired fires on the stalled cycle that brings the count to MEM_TIMEOUT
  assign expired = EN && req && !ready && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || !req || ready) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// RV32I multi-cycle phase sequencer FETCH->DECODE->EXEC->MEM->WB with memory handshakes.
// Strobes are decoded from the registered phase and the current Ready, so a handshake completes in its own cycle.
module multicycle_sequencer
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Run,
  input  logic [6:0]           OpCode,
  input  logic                 RUWrDec,
  input  logic                 DMWrDec,
  input  logic                 IMemReady,
  input  logic                 DMemReady,
  output logic                 IMemReq,
  output logic                 IRWr,
  output logic                 ALUOutWr,
  output logic                 DMemReq,
  output logic                 DMemWr,
  output logic                 MDRWr,
  output logic                 RUWr,
  output logic                 PCWr,
  output logic [INSTRET_W-1:0] InstRet,
  output logic                 Halted,
  output logic [1:0]           ErrCode,
  output logic [2:0]           State
);

  seq_state_t state;
  logic       pending;
  logic       is_store;
  logic       is_mem_op;
  logic       i_done;
  logic       d_done;
  logic       wd_req;
  logic       wd_ready;
  logic       wd_expired;

  assign is_store  = (OpCode == OP_STORE);
  assign is_mem_op = (OpCode == OP_LOAD) || is_store;

  // Gating by rst drops any outstanding request in the reset cycle itself.
  assign IMemReq  = !rst && (state == FETCH) && (Run || pending);
  assign DMemReq  = !rst && (state == MEM);
  assign i_done   = IMemReq && IMemReady;
  assign d_done   = DMemReq && DMemReady;

  assign IRWr     = i_done;
  assign ALUOutWr = !rst && (state == EXEC);
  assign DMemWr   = DMemReq && DMWrDec;
  assign MDRWr    = d_done && !is_store;
  assign RUWr     = !rst && (state == WB) && RUWrDec;
  assign PCWr     = (d_done && is_store) || (!rst && (state == WB));
  assign State    = state;

  // Only one of the two memory ports can be requesting at a time.
  assign wd_req   = IMemReq || DMemReq;
  assign wd_ready = (state == FETCH) ? IMemReady : DMemReady;

  handshake_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .req     (wd_req),
    .ready   (wd_ready),
    .clear   (i_done || d_done || wd_expired),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pending <= 1'b0;
      InstRet <= '0;
      Halted  <= 1'b0;
      ErrCode <= ERR_NONE;
    end else begin
      case (state)
        FETCH: begin
          if (i_done) begin
            pending <= 1'b0;
            state   <= DECODE;
          end else if (wd_expired) begin
            pending <= 1'b0;
            Halted  <= 1'b1;
            ErrCode <= ERR_IMEM_TO;
            state   <= HALT;
          end else if (IMemReq) begin
            pending <= 1'b1;
          end
        end
        DECODE: begin
          if (is_legal_op(OpCode)) begin
            state <= EXEC;
          end else begin
            Halted  <= 1'b1;
            ErrCode <= ERR_ILLEGAL;
            state   <= HALT;
          end
        end
        EXEC: begin
          state <= is_mem_op ? MEM : WB;
        end
        MEM: begin
          if (d_done) begin
            if (is_store) begin
              InstRet <= InstRet + 1'b1;
              state   <= FETCH;
            end else begin
              state <= WB;
            end
          end else if (wd_expired) begin
            Halted  <= 1'b1;
            ErrCode <= ERR_DMEM_TO;
            state   <= HALT;
          end
        end
        WB: begin
          InstRet <= InstRet + 1'b1;
          state   <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
